tone_gen: RTL and testbench

TONE_GEN -- requirements
Module: tone_gen

---
 rtl/tone_gen_if.sv | 11 +
 rtl/tone_gen.sv | 165 ++++++++++++++++
 tb/tb_tone_gen.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tone_gen_if.sv
// Sample stream from the tone generator to the i2s_serdes DAC sample input.
interface tone_gen_if #(
  parameter int DWIDTH = 24
);
  logic [2*DWIDTH-1:0] sample_data;
  logic                sample_valid;
  logic                sample_ready;

  modport master (output sample_data, output sample_valid, input sample_ready);
  modport slave  (input sample_data, input sample_valid, output sample_ready);
endinterface

// File: rtl/tone_gen.sv
// Square/triangle tone generator feeding a stereo valid/ready sample stream.
// Settings are shadowed and only reloaded when the phase wraps, so a period never tears.
module tone_gen #(
  parameter int DWIDTH = 24,
  parameter int PWIDTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enabled,
  input  logic [1:0]        wave_sel,
  input  logic [PWIDTH-1:0] half_period,
  input  logic [DWIDTH-2:0] amplitude,
  input  logic [DWIDTH-2:0] step,
  tone_gen_if.master        dac
);

  localparam int TW = DWIDTH + 1;
  localparam logic [PWIDTH:0] ONE_P = 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  typedef struct packed {
    logic [1:0]        wave;
    logic [PWIDTH-1:0] hp;
    logic [DWIDTH-2:0] amp;
    logic [DWIDTH-2:0] stp;
  } shadow_t;

  // Reset asserts asynchronously, releases two clk edges after reset_n rises.
  logic [1:0] rst_sync;
  logic       rst_n_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n_i = rst_sync[1];

  state_t                 state_q, state_d;
  shadow_t                shd_q, shd_d, port_shd;
  logic [PWIDTH:0]        phase_q, phase_d, phase_last;
  logic signed [TW-1:0]   tri_q, tri_d, step_x, amp_x, tri_up, tri_dn;
  logic                   down_q, down_d;
  logic [DWIDTH-1:0]      smp_q, smp_d;
  logic                   vld_q, vld_d;
  logic                   xfer, wrap, go_idle;

  function automatic logic [PWIDTH-1:0] hp_eff(input logic [PWIDTH-1:0] hp);
    return (hp == '0) ? PWIDTH'(1) : hp;
  endfunction

  function automatic logic [DWIDTH-1:0] wave_val(input shadow_t s, input logic [PWIDTH:0] ph,
                                                 input logic signed [TW-1:0] t);
    logic [DWIDTH-1:0] mag;
    mag = {1'b0, s.amp};
    case (s.wave)
      2'd0:    wave_val = (ph < {1'b0, hp_eff(s.hp)}) ? mag : -mag;
      2'd1:    wave_val = t[DWIDTH-1:0];
      default: wave_val = '0;
    endcase
  endfunction

  assign port_shd   = {wave_sel, half_period, amplitude, step};
  assign xfer       = vld_q & dac.sample_ready;
  assign phase_last = {hp_eff(shd_q.hp), 1'b0} - ONE_P;
  assign wrap       = (phase_q == phase_last);

  // One bit of headroom so tri +/- step never wraps before the clamp compare.
  assign step_x = $signed({2'b00, shd_q.stp});
  assign amp_x  = $signed({2'b00, shd_q.amp});
  assign tri_up = tri_q + step_x;
  assign tri_dn = tri_q - step_x;

  always_comb begin
    state_d = state_q;
    shd_d   = shd_q;
    phase_d = phase_q;
    tri_d   = tri_q;
    down_d  = down_q;
    smp_d   = smp_q;
    vld_d   = vld_q;
    go_idle = 1'b0;

    case (state_q)
      IDLE: begin
        if (enabled) begin
          state_d = RUN;
          shd_d   = port_shd;
          phase_d = '0;
          tri_d   = '0;
          down_d  = 1'b0;
          smp_d   = wave_val(port_shd, '0, '0);
          vld_d   = 1'b1;
        end
      end
      RUN: begin
        if (xfer && enabled) begin
          phase_d = wrap ? '0 : phase_q + ONE_P;
          if (wrap) shd_d = port_shd;
          if (shd_q.wave == 2'd1) begin
            if (!down_q) begin
              if (tri_up >= amp_x) begin
                tri_d  = amp_x;
                down_d = 1'b1;
              end else begin
                tri_d  = tri_up;
              end
            end else begin
              if (tri_dn <= -amp_x) begin
                tri_d  = -amp_x;
                down_d = 1'b0;
              end else begin
                tri_d  = tri_dn;
              end
            end
          end
          // Next sample is registered on the transfer edge for back-to-back streaming.
          smp_d = wave_val(shd_d, phase_d, tri_d);
        end else if (xfer) begin
          go_idle = 1'b1;
        end else if (!enabled) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer) go_idle = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (go_idle) begin
      state_d = IDLE;
      vld_d   = 1'b0;
      phase_d = '0;
      tri_d   = '0;
      down_d  = 1'b0;
      smp_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      shd_q   <= '0;
      phase_q <= '0;
      tri_q   <= '0;
      down_q  <= 1'b0;
      smp_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shd_q   <= shd_d;
      phase_q <= phase_d;
      tri_q   <= tri_d;
      down_q  <= down_d;
      smp_q   <= smp_d;
      vld_q   <= vld_d;
    end
  end

  assign dac.sample_data  = {smp_q, smp_q};
  assign dac.sample_valid = vld_q;

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen: scoreboard of expected mono samples, checked on each transfer.
module tb_tone_gen;
  localparam int DW = 24;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          enabled = 1'b0;
  logic [1:0]    wave_sel = 2'd0;
  logic [PW-1:0] half_period = 16'd3;
  logic [DW-2:0] amplitude = '0;
  logic [DW-2:0] step = '0;

  tone_gen_if #(.DWIDTH(DW)) dac ();

  tone_gen #(.DWIDTH(DW), .PWIDTH(PW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enabled     (enabled),
    .wave_sel    (wave_sel),
    .half_period (half_period),
    .amplitude   (amplitude),
    .step        (step),
    .dac         (dac)
  );

  always #5 clk = ~clk;

  int              checks = 0;
  int              errors = 0;
  logic [DW-1:0]   exp_q[$];
  logic            bp = 1'b0;
  logic            prev_stall = 1'b0;
  logic [2*DW-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [2*DW-1:0] obs, input logic [2*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_sq(input int amp, input int hp, input int n);
    int h;
    logic [DW-1:0] p, m;
    h = (hp == 0) ? 1 : hp;
    p = amp[DW-1:0];
    m = -p;
    for (int i = 0; i < n; i++) exp_q.push_back(((i % (2 * h)) < h) ? p : m);
  endtask

  // Called at negedge: a valid&ready seen here transfers on the coming posedge.
  task automatic monitor();
    logic [DW-1:0] e;
    if (prev_stall) begin
      chk("hold_valid", {47'd0, dac.sample_valid}, 48'd1);
      chk("hold_data", dac.sample_data, prev_data);
    end
    if (dac.sample_valid && dac.sample_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_xfer: observed %0h expected no transfer", dac.sample_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sample", dac.sample_data, {e, e});
      end
    end
    prev_stall = dac.sample_valid && !dac.sample_ready;
    prev_data  = dac.sample_data;
  endtask

  // Enable, stream until the scoreboard drains, and drop enabled on the last transfer.
  task automatic run(input int budget, input int chg_at, input logic [PW-1:0] new_hp,
                     input logic [DW-2:0] new_amp);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    enabled = 1'b1;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (dac.sample_valid && dac.sample_ready) n++;
      monitor();
      if (n == chg_at) begin
        half_period = new_hp;
        amplitude   = new_amp;
      end
      if (exp_q.size() == 0) begin
        enabled = 1'b0;
        done    = 1'b1;
      end
      @(posedge clk);
      #1;
      if (bp) dac.sample_ready = 1'($urandom_range(0, 1));
    end
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL run_timeout: observed %0d outstanding expected 0", exp_q.size());
    end
    exp_q.delete();
    enabled = 1'b0;
    dac.sample_ready = 1'b1;
    @(negedge clk);
    chk("idle_after_run", {47'd0, dac.sample_valid}, 48'd0);
    prev_stall = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int tri_exp[14];
    logic [2*DW-1:0] held;
    tri_exp = '{0, 4, 8, 10, 6, 2, -2, -6, -10, -6, -2, 2, 6, 10};
    dac.sample_ready = 1'b1;

    // Reset state
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {47'd0, dac.sample_valid}, 48'd0);
    chk("reset_data", dac.sample_data, 48'd0);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_valid", {47'd0, dac.sample_valid}, 48'd0);

    // Square, always ready
    wave_sel = 2'd0; amplitude = 23'h100000; half_period = 16'd3;
    push_sq(32'h100000, 3, 12);
    run(100, -1, 16'd3, 23'h100000);

    // Square under random backpressure: same accepted sequence
    bp = 1'b1;
    push_sq(32'h100000, 3, 12);
    run(400, -1, 16'd3, 23'h100000);
    bp = 1'b0;

    // Triangle
    wave_sel = 2'd1; amplitude = 23'd10; step = 23'd4; half_period = 16'd3;
    foreach (tri_exp[i]) exp_q.push_back(tri_exp[i][DW-1:0]);
    run(100, -1, 16'd3, 23'd10);

    // half_period 3 -> 5 during phase 1: current period completes as 3+3
    wave_sel = 2'd0; amplitude = 23'h100; half_period = 16'd3;
    push_sq(32'h100, 3, 6);
    push_sq(32'h100, 5, 10);
    run(100, 2, 16'd5, 23'h100);

    // amplitude change mid-period only takes effect at the wrap
    half_period = 16'd3; amplitude = 23'h100;
    push_sq(32'h100, 3, 6);
    push_sq(32'h200, 3, 6);
    run(100, 2, 16'd3, 23'h200);

    // half_period 0 behaves as 1
    amplitude = 23'h100; half_period = 16'd0;
    push_sq(32'h100, 0, 6);
    run(100, -1, 16'd0, 23'h100);

    // amplitude 0 triangle, then silence codes
    wave_sel = 2'd1; amplitude = '0; step = 23'd3; half_period = 16'd2;
    repeat (6) exp_q.push_back('0);
    run(100, -1, 16'd2, '0);
    wave_sel = 2'd2; amplitude = 23'h100;
    repeat (4) exp_q.push_back('0);
    run(100, -1, 16'd2, 23'h100);
    wave_sel = 2'd3;
    repeat (2) exp_q.push_back('0);
    run(100, -1, 16'd2, 23'h100);

    // Disable under stall: held through DRAIN, enabled pulse ignored
    wave_sel = 2'd0; half_period = 16'd3; amplitude = 23'h123;
    dac.sample_ready = 1'b0; enabled = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (dac.sample_valid) break;
    end
    chk("stall_valid", {47'd0, dac.sample_valid}, 48'd1);
    chk("stall_data", dac.sample_data, {24'h000123, 24'h000123});
    held = dac.sample_data;
    enabled = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_valid", {47'd0, dac.sample_valid}, 48'd1);
      chk("drain_data", dac.sample_data, held);
      if (i == 1) enabled = 1'b1;
      if (i == 2) enabled = 1'b0;
    end
    exp_q.push_back(24'h000123);
    dac.sample_ready = 1'b1;
    prev_stall = 1'b0;
    monitor();
    @(negedge clk);
    chk("drain_idle", {47'd0, dac.sample_valid}, 48'd0);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain_accept: observed %0d outstanding expected 0", exp_q.size());
    end
    exp_q.delete();

    // Reset mid-stream, then synchronised release and restart
    amplitude = 23'h100; half_period = 16'd3;
    dac.sample_ready = 1'b0; enabled = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (dac.sample_valid) break;
    end
    chk("pre_reset_valid", {47'd0, dac.sample_valid}, 48'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_valid", {47'd0, dac.sample_valid}, 48'd0);
    chk("async_reset_data", dac.sample_data, 48'd0);
    enabled = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    enabled = 1'b1;
    @(negedge clk);
    chk("sync_release1", {47'd0, dac.sample_valid}, 48'd0);
    @(negedge clk);
    chk("sync_release2", {47'd0, dac.sample_valid}, 48'd0);
    @(negedge clk);
    chk("restart_valid", {47'd0, dac.sample_valid}, 48'd1);
    @(posedge clk);
    #1;
    push_sq(32'h100, 3, 4);
    dac.sample_ready = 1'b1;
    prev_stall = 1'b0;
    run(50, -1, 16'd3, 23'h100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
